bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 21 ++
 rtl/bus_arbiter_if.sv | 63 ++++++
 rtl/bus_arbiter_rr_pick.sv | 34 +++
 rtl/bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_pkg
//  Description : Shared types and constants for the two-master bus arbiter.
//                - state_t  : arbiter FSM state (IDLE, ISSUE, RESP)
//                - M0 / M1  : master index constants used for winner/last-grant
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_if
//  Description : Bundle of all master handshake signals and the shared bus.
//                Ports (per master n = 0/1):
//                  mn_req, mn_we, mn_addr, mn_wdata  : requester -> arbiter
//                  mn_gnt, mn_rdata, mn_rvalid       : arbiter -> requester
//                Shared bus:
//                  bus_address, bus_write_data, bus_write_enable,
//                  bus_read_enable, busy              : arbiter -> bus
//                  bus_read_data                      : bus -> arbiter
//                modport master : the environment side (masters + slave)
//                modport slave  : the arbiter side
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_rvalid;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_rvalid;

    logic [ADDR_W-1:0] bus_address;
    logic [DATA_W-1:0] bus_write_data;
    logic              bus_write_enable;
    logic              bus_read_enable;
    logic [DATA_W-1:0] bus_read_data;
    logic              busy;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output bus_read_data,
        input  m0_gnt, m0_rdata, m0_rvalid,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  bus_address, bus_write_data, bus_write_enable, bus_read_enable, busy
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  bus_read_data,
        output m0_gnt, m0_rdata, m0_rvalid,
        output m1_gnt, m1_rdata, m1_rvalid,
        output bus_address, bus_write_data, bus_write_enable, bus_read_enable, busy
    );

endinterface : bus_arbiter_if
`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational two-way round-robin selector.
//                  reqs[1:0] : request vector, bit n = master n
//                  last      : master granted most recently
//                  winner    : selected master index (valid when any = 1)
//                  any       : at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import bus_arbiter_pkg::*;
(
    input  wire logic [1:0] reqs,
    input  wire logic       last,
    output logic            winner,
    output logic            any
);

    always_comb begin
        winner = M0;
        unique case (reqs)
            2'b01:   winner = M0;
            2'b10:   winner = M1;
            // Tie: the master that did not win last time goes first.
            2'b11:   winner = (last == M0) ? M1 : M0;
            default: winner = M0;
        endcase
    end

    assign any = |reqs;

endmodule : rr_pick
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-master round-robin arbiter onto a single shared bus with
//                one transaction outstanding at a time.
//                  clk   : single clock, rising edge
//                  reset : asynchronous, active-low
//                  bif   : bus_arbiter_if.slave (master handshakes + bus)
//                Flow: IDLE -(request)-> ISSUE -(write)-> IDLE
//                                              -(read)-> RESP -> IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  wire logic      clk,
    input  wire logic      reset,
    bus_arbiter_if.slave   bif
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_grant;
    logic              w_capture;

    logic [1:0]        w_reqs;
    logic              w_pick;
    logic              w_any;

    // r_last_gnt doubles as the owner of the transaction in flight.
    logic              r_last_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_rvalid0;
    logic              r_rvalid1;

    assign w_reqs = {bif.m1_req, bif.m0_req};

    rr_pick u_rr_pick (
        .reqs   (w_reqs),
        .last   (r_last_gnt),
        .winner (w_pick),
        .any    (w_any)
    );

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next = ISSUE;
                    w_grant      = 1'b1;
                end
            end
            ISSUE: begin
                w_state_next = r_we ? IDLE : RESP;
            end
            RESP: begin
                // Slave data is valid now, one cycle after the read strobe.
                w_state_next = IDLE;
                w_capture    = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Transaction registers and read-return path
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_gnt <= M1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_rvalid0 <= w_capture && (r_last_gnt == M0);
            r_rvalid1 <= w_capture && (r_last_gnt == M1);

            if (w_grant) begin
                r_last_gnt <= w_pick;
                if (w_pick == M1) begin
                    r_we    <= bif.m1_we;
                    r_addr  <= bif.m1_addr;
                    r_wdata <= bif.m1_wdata;
                end else begin
                    r_we    <= bif.m0_we;
                    r_addr  <= bif.m0_addr;
                    r_wdata <= bif.m0_wdata;
                end
            end

            if (w_capture) begin
                if (r_last_gnt == M1) begin
                    r_rdata1 <= bif.bus_read_data;
                end else begin
                    r_rdata0 <= bif.bus_read_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Strobes and grants decode straight from the state register so
    // an asynchronous reset drops them in the same instant.
    // ------------------------------------------------------------------------
    assign bif.m0_gnt           = (r_state == ISSUE) && (r_last_gnt == M0);
    assign bif.m1_gnt           = (r_state == ISSUE) && (r_last_gnt == M1);
    assign bif.bus_write_enable = (r_state == ISSUE) &&  r_we;
    assign bif.bus_read_enable  = (r_state == ISSUE) && !r_we;
    assign bif.bus_address      = r_addr;
    assign bif.bus_write_data   = r_wdata;
    assign bif.busy             = (r_state != IDLE);
    assign bif.m0_rdata         = r_rdata0;
    assign bif.m1_rdata         = r_rdata1;
    assign bif.m0_rvalid        = r_rvalid0;
    assign bif.m1_rvalid        = r_rvalid1;

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter: directed vector table,
//                hand-written corner sequences and randomized traffic checked
//                against a transaction-timing reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.m0_req = 1'b0; bif.m0_we = 1'b0; bif.m0_addr = '0; bif.m0_wdata = '0;
        bif.m1_req = 1'b0; bif.m1_we = 1'b0; bif.m1_addr = '0; bif.m1_wdata = '0;
        bif.bus_read_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Reference model: transactions described by timestamps. A grant at edge
    // e occupies the bus until e+2 (write) or e+3 (read); a read returns the
    // slave data seen at edge e+2.
    // ------------------------------------------------------------------------
    logic [1:0]  m_gnt;
    logic [1:0]  m_rv;
    logic        m_wen, m_ren, m_busy;
    logic [63:0] m_addr, m_wdata;
    logic [63:0] m_rdata [2];
    int          m_last, m_free_at, m_rd_edge, m_rd_who;
    bit          m_rd_pend;

    task automatic model_init();
        m_gnt = 2'b00; m_rv = 2'b00; m_wen = 1'b0; m_ren = 1'b0; m_busy = 1'b0;
        m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
        m_last = 1; m_free_at = 0; m_rd_edge = 0; m_rd_who = 0; m_rd_pend = 0;
    endtask

    task automatic model_edge(input int e);
        logic [1:0] reqs;
        int         w;
        logic       we;
        m_gnt = 2'b00; m_rv = 2'b00; m_wen = 1'b0; m_ren = 1'b0;
        if (m_rd_pend && e == m_rd_edge) begin
            m_rdata[m_rd_who] = bif.bus_read_data;
            m_rv[m_rd_who]    = 1'b1;
            m_rd_pend         = 0;
        end
        reqs = {bif.m1_req, bif.m0_req};
        if (e >= m_free_at && reqs != 2'b00) begin
            if (reqs == 2'b11) w = 1 - m_last;
            else               w = reqs[1] ? 1 : 0;
            we        = (w == 1) ? bif.m1_we : bif.m0_we;
            m_addr    = (w == 1) ? bif.m1_addr : bif.m0_addr;
            m_wdata   = (w == 1) ? bif.m1_wdata : bif.m0_wdata;
            m_gnt[w]  = 1'b1;
            m_wen     = we;
            m_ren     = !we;
            m_last    = w;
            m_free_at = e + (we ? 2 : 3);
            if (!we) begin
                m_rd_pend = 1; m_rd_edge = e + 2; m_rd_who = w;
            end
        end
        m_busy = (e + 1 < m_free_at);
    endtask

    task automatic model_compare();
        chk("rnd_gnt0",   bif.m0_gnt,           m_gnt[0]);
        chk("rnd_gnt1",   bif.m1_gnt,           m_gnt[1]);
        chk("rnd_wen",    bif.bus_write_enable, m_wen);
        chk("rnd_ren",    bif.bus_read_enable,  m_ren);
        chk("rnd_addr",   bif.bus_address,      m_addr);
        chk("rnd_wdata",  bif.bus_write_data,   m_wdata);
        chk("rnd_rv0",    bif.m0_rvalid,        m_rv[0]);
        chk("rnd_rv1",    bif.m1_rvalid,        m_rv[1]);
        chk("rnd_rdata0", bif.m0_rdata,         m_rdata[0]);
        chk("rnd_rdata1", bif.m1_rdata,         m_rdata[1]);
        chk("rnd_busy",   bif.busy,             m_busy);
        chk("rnd_gnt_excl", bif.m0_gnt & bif.m1_gnt, 1'b0);
        chk("rnd_rv_excl",  bif.m0_rvalid & bif.m1_rvalid, 1'b0);
    endtask

    task automatic drive_random();
        if (m_gnt[0] || (bif.m0_req && $urandom_range(15) == 0)) begin
            bif.m0_req = 1'b0;
        end else if (!bif.m0_req && $urandom_range(2) == 0) begin
            bif.m0_req   = 1'b1;
            bif.m0_we    = 1'($urandom_range(1));
            bif.m0_addr  = {$urandom, $urandom};
            bif.m0_wdata = {$urandom, $urandom};
        end
        if (m_gnt[1] || (bif.m1_req && $urandom_range(15) == 0)) begin
            bif.m1_req = 1'b0;
        end else if (!bif.m1_req && $urandom_range(2) == 0) begin
            bif.m1_req   = 1'b1;
            bif.m1_we    = 1'($urandom_range(1));
            bif.m1_addr  = {$urandom, $urandom};
            bif.m1_wdata = {$urandom, $urandom};
        end
        bif.bus_read_data = {$urandom, $urandom};
    endtask

    // ------------------------------------------------------------------------
    // Directed arbitration table, applied from IDLE one row at a time.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic        req0;
        logic        we0;
        logic        req1;
        logic        we1;
        logic        gnt0;
        logic        gnt1;
        logic        wen;
        logic        ren;
        logic [63:0] addr;
    } vec_t;

    vec_t tbl [7];
    int   order [4];
    int   n_gnt;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        idle_inputs();
        model_init();

        // ---- reset state ----
        tick();
        chk("rst_gnt0",   bif.m0_gnt,           1'b0);
        chk("rst_gnt1",   bif.m1_gnt,           1'b0);
        chk("rst_wen",    bif.bus_write_enable, 1'b0);
        chk("rst_ren",    bif.bus_read_enable,  1'b0);
        chk("rst_busy",   bif.busy,             1'b0);
        chk("rst_rv0",    bif.m0_rvalid,        1'b0);
        chk("rst_rv1",    bif.m1_rvalid,        1'b0);
        chk("rst_addr",   bif.bus_address,      64'h0);
        chk("rst_wdata",  bif.bus_write_data,   64'h0);
        chk("rst_rdata0", bif.m0_rdata,         64'h0);
        chk("rst_rdata1", bif.m1_rdata,         64'h0);
        do_reset();

        // ---- m0 write after reset release ----
        bif.m0_req = 1'b1; bif.m0_we = 1'b1;
        bif.m0_addr = 64'h8000_0000; bif.m0_wdata = 64'h41;
        tick();
        chk("wr_gnt0",  bif.m0_gnt,           1'b1);
        chk("wr_gnt1",  bif.m1_gnt,           1'b0);
        chk("wr_wen",   bif.bus_write_enable, 1'b1);
        chk("wr_ren",   bif.bus_read_enable,  1'b0);
        chk("wr_addr",  bif.bus_address,      64'h8000_0000);
        chk("wr_wdata", bif.bus_write_data,   64'h41);
        chk("wr_busy",  bif.busy,             1'b1);
        bif.m0_req = 1'b0;
        tick();
        chk("wr_gnt0_off", bif.m0_gnt,           1'b0);
        chk("wr_wen_off",  bif.bus_write_enable, 1'b0);
        chk("wr_busy_off", bif.busy,             1'b0);
        chk("wr_addr_hold", bif.bus_address,     64'h8000_0000);
        chk("wr_data_hold", bif.bus_write_data,  64'h41);

        // ---- m1 read, slave returns 0x55 ----
        bif.m1_req = 1'b1; bif.m1_we = 1'b0; bif.m1_addr = 64'h1000;
        bif.bus_read_data = 64'h55;
        tick();
        chk("rd_gnt1", bif.m1_gnt,          1'b1);
        chk("rd_ren",  bif.bus_read_enable, 1'b1);
        chk("rd_addr", bif.bus_address,     64'h1000);
        bif.m1_req = 1'b0;
        tick();
        chk("rd_ren_off", bif.bus_read_enable, 1'b0);
        chk("rd_busy",    bif.busy,            1'b1);
        chk("rd_rv1_early", bif.m1_rvalid,     1'b0);
        tick();
        chk("rd_rv1",    bif.m1_rvalid, 1'b1);
        chk("rd_rv0",    bif.m0_rvalid, 1'b0);
        chk("rd_rdata1", bif.m1_rdata,  64'h55);
        chk("rd_rdata0", bif.m0_rdata,  64'h0);
        chk("rd_busy_off", bif.busy,    1'b0);
        bif.bus_read_data = 64'hDEAD;
        tick();
        chk("rd_rv1_off",  bif.m1_rvalid, 1'b0);
        chk("rd_rdata1_hold", bif.m1_rdata, 64'h55);

        // ---- arbitration table ----
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h8000_0000};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h1000};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h8000_0000};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h1000};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0000};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h1000};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bif.m0_req = tbl[i].req0; bif.m0_we = tbl[i].we0;
            bif.m0_addr = 64'h8000_0000; bif.m0_wdata = 64'h41;
            bif.m1_req = tbl[i].req1; bif.m1_we = tbl[i].we1;
            bif.m1_addr = 64'h1000; bif.m1_wdata = 64'h99;
            tick();
            chk($sformatf("tbl%0d_gnt0", i), bif.m0_gnt,           tbl[i].gnt0);
            chk($sformatf("tbl%0d_gnt1", i), bif.m1_gnt,           tbl[i].gnt1);
            chk($sformatf("tbl%0d_wen", i),  bif.bus_write_enable, tbl[i].wen);
            chk($sformatf("tbl%0d_ren", i),  bif.bus_read_enable,  tbl[i].ren);
            chk($sformatf("tbl%0d_addr", i), bif.bus_address,      tbl[i].addr);
            bif.m0_req = 1'b0; bif.m1_req = 1'b0;
            repeat (3) tick();
        end

        // ---- both held for 4 transactions: grants alternate ----
        do_reset();
        bif.m0_req = 1'b1; bif.m0_we = 1'b1; bif.m0_addr = 64'h10;
        bif.m1_req = 1'b1; bif.m1_we = 1'b1; bif.m1_addr = 64'h20;
        n_gnt = 0;
        for (int c = 0; c < 20 && n_gnt < 4; c++) begin
            tick();
            chk("alt_gnt_excl", bif.m0_gnt & bif.m1_gnt, 1'b0);
            if (bif.m0_gnt) begin order[n_gnt] = 0; n_gnt++; end
            else if (bif.m1_gnt) begin order[n_gnt] = 1; n_gnt++; end
        end
        bif.m0_req = 1'b0; bif.m1_req = 1'b0;
        chk("alt_count", 64'(n_gnt), 64'd4);
        for (int i = 0; i < n_gnt; i++) chk($sformatf("alt_order%0d", i), 64'(order[i]), 64'(i % 2));
        repeat (3) tick();

        // ---- m1 request raised while m0 read is in RESP ----
        bif.m0_req = 1'b1; bif.m0_we = 1'b0; bif.m0_addr = 64'h300;
        bif.bus_read_data = 64'h77;
        tick();
        chk("resp_gnt0", bif.m0_gnt, 1'b1);
        bif.m0_req = 1'b0;
        tick();
        bif.m1_req = 1'b1; bif.m1_we = 1'b1; bif.m1_addr = 64'h400;
        tick();
        chk("resp_rv0",    bif.m0_rvalid, 1'b1);
        chk("resp_rdata0", bif.m0_rdata,  64'h77);
        chk("resp_no_gnt1", bif.m1_gnt,   1'b0);
        tick();
        chk("resp_gnt1",  bif.m1_gnt,      1'b1);
        chk("resp_addr1", bif.bus_address, 64'h400);
        bif.m1_req = 1'b0;
        repeat (2) tick();

        // ---- reset during ISSUE of a read ----
        bif.m0_req = 1'b1; bif.m0_we = 1'b0; bif.m0_addr = 64'h500;
        tick();
        chk("abort_ren_pre", bif.bus_read_enable, 1'b1);
        bif.m0_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("abort_ren",  bif.bus_read_enable, 1'b0);
        chk("abort_busy", bif.busy,            1'b0);
        chk("abort_gnt0", bif.m0_gnt,          1'b0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("abort_no_rv0", bif.m0_rvalid, 1'b0);
            chk("abort_no_rv1", bif.m1_rvalid, 1'b0);
        end

        // ---- m1 pulse during ISSUE of m0, dropped before IDLE ----
        bif.m0_req = 1'b1; bif.m0_we = 1'b1; bif.m0_addr = 64'h600;
        tick();
        chk("pulse_gnt0", bif.m0_gnt, 1'b1);
        bif.m0_req = 1'b0;
        bif.m1_req = 1'b1; bif.m1_we = 1'b1; bif.m1_addr = 64'h700;
        #3 bif.m1_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("pulse_no_gnt1", bif.m1_gnt,           1'b0);
            chk("pulse_no_wen",  bif.bus_write_enable, 1'b0);
            chk("pulse_no_ren",  bif.bus_read_enable,  1'b0);
        end

        // ---- randomized traffic against the reference model ----
        do_reset();
        model_init();
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            model_edge(c);
            tick();
            model_compare();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bus_arbiter
`default_nettype wire
